mobilenetv3_sequence_optimized: RTL and testbench

Fixed-depth pipeline of 11 simplified MobileNetV3 bottleneck stages for streaming pixels. Each stage applies one activation to one tagged sample per clock and passes the sample's channel/row/col tags along with it. The block sits under the optimized MobileNetV3 top, which registers the input stream into it. It uses no memory files and no external weights.

---
 rtl/mobilenetv3_sequence_optimized_if.sv | 28 ++
 rtl/mobilenetv3_sequence_optimized.sv | 140 ++++++++++++++
 tb/tb_mobilenetv3_sequence_optimized.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mobilenetv3_sequence_optimized_if.sv
// Streaming pixel bus for the MobileNetV3 bottleneck sequence: tagged input
// samples in, activated tagged samples out, plus ready/done status.
interface mobilenetv3_sequence_optimized_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic [7:0]                   channel_in;
  logic [7:0]                   row_in;
  logic [7:0]                   col_in;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic [7:0]                   channel_out;
  logic [7:0]                   row_out;
  logic [7:0]                   col_out;
  logic                         ready;
  logic                         done;

  modport master (
    output valid_in, data_in, channel_in, row_in, col_in,
    input  valid_out, data_out, channel_out, row_out, col_out, ready, done
  );

  modport slave (
    input  valid_in, data_in, channel_in, row_in, col_in,
    output valid_out, data_out, channel_out, row_out, col_out, ready, done
  );
endinterface

// File: rtl/mobilenetv3_sequence_optimized.sv
// Eleven-stage activation pipeline (3x ReLU, 8x hard-swish) for Q8.8 samples,
// with tags riding alongside each sample and a frame-complete pulse.
module mobilenetv3_sequence_optimized #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] LAST_CH    = 8'd15,
  parameter logic [7:0] LAST_ROW   = 8'd223,
  parameter logic [7:0] LAST_COL   = 8'd223
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mobilenetv3_sequence_optimized_if.slave bus
);
  localparam int NUM_BLOCKS  = 11;
  localparam int RELU_BLOCKS = 3;
  localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (DATA_WIDTH - 1)) - 48'sd1;
  localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (DATA_WIDTH - 1));

  function automatic logic signed [DATA_WIDTH-1:0] relu_f(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] y_s;
    if (x[DATA_WIDTH-1]) begin
      y_s = '0;
    end else begin
      y_s = x;
    end
    return y_s;
  endfunction

  // x * clamp(x + 3, 0, 6) / 6 in Q8.8, with 43/256 standing in for 1/6
  function automatic logic signed [DATA_WIDTH-1:0] hswish_f(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [31:0]           sum_s;
    logic signed [31:0]           t_s;
    logic signed [31:0]           p_s;
    logic signed [47:0]           q_s;
    logic signed [DATA_WIDTH-1:0] y_s;
    sum_s = 32'(x) + 32'sd768;
    if (sum_s < 32'sd0) begin
      t_s = 32'sd0;
    end else if (sum_s > 32'sd1536) begin
      t_s = 32'sd1536;
    end else begin
      t_s = sum_s;
    end
    p_s = (32'(x) * t_s) >>> 6'd8;
    q_s = (48'(p_s) * 48'sd43) >>> 6'd8;
    if (q_s > SAT_MAX) begin
      y_s = SAT_MAX[DATA_WIDTH-1:0];
    end else if (q_s < SAT_MIN) begin
      y_s = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      y_s = q_s[DATA_WIDTH-1:0];
    end
    return y_s;
  endfunction

  logic                         in_valid_r;
  logic signed [DATA_WIDTH-1:0] in_data_r;
  logic [7:0]                   in_ch_r;
  logic [7:0]                   in_row_r;
  logic [7:0]                   in_col_r;

  logic [NUM_BLOCKS-1:0]        block_valid_out;
  logic signed [DATA_WIDTH-1:0] stage_data_r [NUM_BLOCKS];
  logic [7:0]                   stage_ch_r   [NUM_BLOCKS];
  logic [7:0]                   stage_row_r  [NUM_BLOCKS];
  logic [7:0]                   stage_col_r  [NUM_BLOCKS];

  logic                         done_r;
  logic                         ready_r;

  // Input capture register followed by the activation stages; data/tags hold on bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_r      <= 1'b0;
      in_data_r       <= '0;
      in_ch_r         <= 8'd0;
      in_row_r        <= 8'd0;
      in_col_r        <= 8'd0;
      block_valid_out <= '0;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        stage_data_r[k] <= '0;
        stage_ch_r[k]   <= 8'd0;
        stage_row_r[k]  <= 8'd0;
        stage_col_r[k]  <= 8'd0;
      end
    end else begin
      in_valid_r <= bus.valid_in;
      if (bus.valid_in) begin
        in_data_r <= bus.data_in;
        in_ch_r   <= bus.channel_in;
        in_row_r  <= bus.row_in;
        in_col_r  <= bus.col_in;
      end
      block_valid_out <= {block_valid_out[NUM_BLOCKS-2:0], in_valid_r};
      if (in_valid_r) begin
        stage_data_r[0] <= relu_f(in_data_r);
        stage_ch_r[0]   <= in_ch_r;
        stage_row_r[0]  <= in_row_r;
        stage_col_r[0]  <= in_col_r;
      end
      for (int k = 1; k < NUM_BLOCKS; k++) begin
        if (block_valid_out[k-1]) begin
          stage_data_r[k] <= (k < RELU_BLOCKS) ? relu_f(stage_data_r[k-1])
                                               : hswish_f(stage_data_r[k-1]);
          stage_ch_r[k]   <= stage_ch_r[k-1];
          stage_row_r[k]  <= stage_row_r[k-1];
          stage_col_r[k]  <= stage_col_r[k-1];
        end
      end
    end
  end

  // Frame-complete pulse, one edge after the final-tagged sample leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= block_valid_out[NUM_BLOCKS-1]
                && (stage_ch_r[NUM_BLOCKS-1]  == LAST_CH)
                && (stage_row_r[NUM_BLOCKS-1] == LAST_ROW)
                && (stage_col_r[NUM_BLOCKS-1] == LAST_COL);
    end
  end

  // Always ready outside reset: the pipeline never stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

  assign bus.valid_out   = block_valid_out[NUM_BLOCKS-1];
  assign bus.data_out    = stage_data_r[NUM_BLOCKS-1];
  assign bus.channel_out = stage_ch_r[NUM_BLOCKS-1];
  assign bus.row_out     = stage_row_r[NUM_BLOCKS-1];
  assign bus.col_out     = stage_col_r[NUM_BLOCKS-1];
  assign bus.done        = done_r;
  assign bus.ready       = ready_r;
endmodule

// File: tb/tb_mobilenetv3_sequence_optimized.sv
// Directed bench for the activation sequence: a cycle-indexed expectation
// table filled from an arithmetic model, checked against the DUT every cycle.
module tb_mobilenetv3_sequence_optimized;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;

  bit         ev  [2048];
  bit         edn [2048];
  longint     ed  [2048];
  bit [7:0]   ech [2048];
  bit [7:0]   erw [2048];
  bit [7:0]   ecl [2048];

  mobilenetv3_sequence_optimized_if #(.DATA_WIDTH(16)) bus ();

  mobilenetv3_sequence_optimized #(
    .DATA_WIDTH(16), .LAST_CH(8'd15), .LAST_ROW(8'd223), .LAST_COL(8'd223)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint hs_m(input longint x);
    longint t, p, q;
    t = x + 768;
    if (t < 0) t = 0;
    if (t > 1536) t = 1536;
    p = (x * t) >>> 8;
    q = (p * 43) >>> 8;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  function automatic longint pipe_m(input longint x);
    longint y = x;
    for (int k = 0; k < 11; k++) begin
      if (k < 3) y = (y < 0) ? 0 : y;
      else       y = hs_m(y);
    end
    return y;
  endfunction

  // Model + compare: expectation for edge n+11 (data) and n+12 (done)
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= 14; i++) begin
        ev[e+i]  = 1'b0;
        edn[e+i] = 1'b0;
      end
    end else begin
      e++;
      if (bus.valid_in) begin
        ev[e+11]  = 1'b1;
        ed[e+11]  = pipe_m(longint'(bus.data_in));
        ech[e+11] = bus.channel_in;
        erw[e+11] = bus.row_in;
        ecl[e+11] = bus.col_in;
        if (bus.channel_in == 8'd15 && bus.row_in == 8'd223 && bus.col_in == 8'd223)
          edn[e+12] = 1'b1;
      end
      #1;
      chk("valid_out", bus.valid_out, ev[e]);
      if (ev[e]) begin
        chk("data_out", bus.data_out, ed[e]);
        chk("channel_out", bus.channel_out, ech[e]);
        chk("row_out", bus.row_out, erw[e]);
        chk("col_out", bus.col_out, ecl[e]);
      end
      chk("done", bus.done, edn[e]);
      chk("ready", bus.ready, 1);
    end
  end

  task automatic drive(input bit v, input int d, input int ch, input int r, input int c);
    @(negedge clk);
    bus.valid_in   = v;
    bus.data_in    = 16'(d);
    bus.channel_in = 8'(ch);
    bus.row_in     = 8'(r);
    bus.col_in     = 8'(c);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h1234, 15, 223, 223);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = '0;
    bus.channel_in = 8'd0; bus.row_in = 8'd0; bus.col_in = 8'd0;

    chk("pin_hs_256", hs_m(256), 172);
    chk("pin_hs_m300", hs_m(-300), -93);
    chk("pin_pipe_256", pipe_m(256), 2);
    chk("pin_pipe_32767", pipe_m(32767), 32767);
    chk("pin_pipe_m512", pipe_m(-512), 0);

    #3;
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_block_valid", dut.block_valid_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single full-scale sample with literal timing checks
    drive(1'b1, 32767, 3, 10, 20);
    @(posedge clk); #1;
    chk("bvo0_edge0", dut.block_valid_out[0], 0);
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    chk("bvo0_edge1", dut.block_valid_out[0], 1);
    repeat (10) @(posedge clk);
    #1;
    chk("lit_valid", bus.valid_out, 1);
    chk("lit_data", bus.data_out, 32767);
    chk("lit_ch", bus.channel_out, 3);
    chk("lit_row", bus.row_out, 10);
    chk("lit_col", bus.col_out, 20);
    @(posedge clk); #1;
    chk("lit_valid_drop", bus.valid_out, 0);
    chk("lit_data_hold", bus.data_out, 32767);
    idle(3);

    drive(1'b1, -512, 1, 2, 3);
    drive(1'b1, 0, 2, 3, 4);
    idle(2);
    drive(1'b1, 256, 5, 6, 7);
    idle(4);
    drive(1'b1, 32767, 8, 9, 10);
    idle(2);
    for (int i = 0; i < 20; i++) drive(1'b1, i * 100 - 900, i, i + 1, i + 2);
    idle(2);

    drive(1'b1, 1000, 15, 223, 223);
    idle(3);
    drive(1'b1, 1000, 14, 223, 223);
    idle(2);
    drive(1'b1, -5, 15, 223, 223);
    drive(1'b1, 77, 15, 223, 223);
    drive(1'b1, 5, 15, 222, 223);
    drive(1'b1, 5, 15, 223, 222);
    drive(1'b0, 123, 15, 223, 223);
    idle(14);

    // Mid-stream asynchronous reset flushes everything in flight
    drive(1'b1, 300, 15, 223, 223);
    drive(1'b1, 400, 1, 1, 1);
    drive(1'b1, 500, 2, 2, 2);
    drive(1'b1, 600, 3, 3, 3);
    drive(1'b1, 700, 15, 223, 223);
    idle(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.valid_out, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_block_valid", dut.block_valid_out, 0);
    chk("mid_rst_ready", bus.ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
